pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer.sv | 145 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Sequences the core PLL through power-up reset, lock
//               qualification and loss-of-lock recovery. Drives the PLL
//               reset and a core reset that is released only once lock has
//               been stable for LOCK_STABLE_CYCLES refclk cycles.
//               Single clock domain (refclk).
// Ports       :
//   refclk       in   reference clock (sole clock)
//   rst          in   asynchronous active-high reset
//   pll_locked   in   PLL lock indication, asynchronous to refclk
//   restart      in   single-cycle request to re-run the full sequence
//   pll_rst      out  PLL reset, high only in HOLD
//   core_rst     out  core reset, low only in RUN
//   ready        out  high only in RUN
//   state        out  current state (HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3)
//   relock_count out  saturating count of lock losses seen in RUN
//   timeout_err  out  sticky lock-timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int unsigned CNT_W               = 24
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] relock_count,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // Terminal counts, one less than the cycle counts since cnt starts at 0.
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  state_t           cur_state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [7:0]       relock_next;
  logic             timeout_next;
  logic             sync_meta;
  logic             locked_s;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      sync_meta <= pll_locked;
      locked_s  <= sync_meta;
    end
  end

  always_comb begin
    next_state   = cur_state;
    cnt_next     = cnt + CNT_W'(1);
    relock_next  = relock_count;
    timeout_next = timeout_err;

    case (cur_state)
      HOLD: begin
        if (cnt == HOLD_LAST) next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // A lock seen on the final timeout cycle still wins over the retry.
        if (locked_s) begin
          next_state = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          next_state   = HOLD;
          timeout_next = 1'b1;
        end
      end
      STABLE: begin
        // Losing lock here is not counted as a relock; qualification
        // simply starts over with a fresh timeout window.
        if (!locked_s) begin
          next_state = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          next_state = RUN;
        end
      end
      RUN: begin
        cnt_next = cnt;
        if (!locked_s) begin
          next_state = HOLD;
          if (relock_count != 8'hFF) relock_next = relock_count + 8'd1;
        end
      end
      default: next_state = HOLD;
    endcase

    // Restart overrides everything except the relock history.
    if (restart) begin
      next_state   = HOLD;
      timeout_next = 1'b0;
      relock_next  = relock_count;
    end

    if (restart || (next_state != cur_state)) cnt_next = '0;
  end

  // Outputs are decoded from next_state so they change on the same edge
  // as the state register while remaining registered.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cur_state    <= HOLD;
      cnt          <= '0;
      relock_count <= 8'd0;
      timeout_err  <= 1'b0;
      pll_rst      <= 1'b1;
      core_rst     <= 1'b1;
      ready        <= 1'b0;
    end else begin
      cur_state    <= next_state;
      cnt          <= cnt_next;
      relock_count <= relock_next;
      timeout_err  <= timeout_next;
      pll_rst      <= (next_state == HOLD);
      core_rst     <= (next_state != RUN);
      ready        <= (next_state == RUN);
    end
  end

  assign state = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Scoreboard bench for pll_reset_sequencer. The stimulus
//               process queues the expected output snapshot for a given
//               refclk edge; a monitor process compares the DUT outputs at
//               the falling edge following that rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       core_rst;
  logic       ready;
  logic [1:0] state;
  logic [7:0] relock_count;
  logic       timeout_err;

  int tests;
  int fails;
  int cyc;

  typedef struct {
    int         cyc;
    string      name;
    logic [1:0] st;
    logic       prst;
    logic       crst;
    logic       rdy;
    logic [7:0] rc;
    logic       to;
  } exp_t;

  exp_t q[$];

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES    (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .CNT_W              (24)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .restart     (restart),
    .pll_rst     (pll_rst),
    .core_rst    (core_rst),
    .ready       (ready),
    .state       (state),
    .relock_count(relock_count),
    .timeout_err (timeout_err)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // cyc is the number of rising edges seen so far.
  initial cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input string n, input logic [1:0] st,
                           input logic prst, input logic crst, input logic rdy,
                           input logic [7:0] rc, input logic to);
    exp_t e;
    e.cyc = c; e.name = n; e.st = st; e.prst = prst; e.crst = crst;
    e.rdy = rdy; e.rc = rc; e.to = to;
    q.push_back(e);
  endtask

  // Advance to 1 time unit after rising edge number k.
  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic monitor();
    exp_t        e;
    logic [13:0] act;
    logic [13:0] req;
    forever begin
      @(negedge refclk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e   = q.pop_front();
        act = {state, pll_rst, core_rst, ready, relock_count, timeout_err};
        req = {e.st, e.prst, e.crst, e.rdy, e.rc, e.to};
        tests++;
        if (e.cyc != cyc || act !== req) begin
          fails++;
          $display("FAIL %s @edge %0d (checked at %0d): got st=%0d prst=%b crst=%b rdy=%b rc=%0d to=%b, want st=%0d prst=%b crst=%b rdy=%b rc=%0d to=%b",
                   e.name, e.cyc, cyc, state, pll_rst, core_rst, ready, relock_count, timeout_err,
                   e.st, e.prst, e.crst, e.rdy, e.rc, e.to);
        end
      end
    end
  endtask

  initial begin
    #400000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, %0d checks still queued", q.size());
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, l0, w0, r0, x0, x, rc_exp;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    pll_locked = 1'b0;
    restart = 1'b0;
    fork monitor(); join_none

    // Reset state while rst is held.
    expect_at(3, "reset_state", 2'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    goto(5);
    rst = 1'b0;
    c0 = cyc;

    // Power-up with clean lock.
    expect_at(c0 + 3,  "pu_hold_end",   2'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    expect_at(c0 + 4,  "pu_wait_entry", 2'd1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    expect_at(c0 + 8,  "pu_wait_sync",  2'd1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    expect_at(c0 + 9,  "pu_stable",     2'd2, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    expect_at(c0 + 16, "pu_stable_end", 2'd2, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    expect_at(c0 + 17, "pu_run",        2'd3, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
    goto(c0 + 6);
    pll_locked = 1'b1;
    goto(c0 + 17);

    // Loss of lock in RUN.
    l0 = cyc;
    pll_locked = 1'b0;
    expect_at(l0 + 2, "loss_still_run", 2'd3, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
    expect_at(l0 + 3, "loss_hold",      2'd0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0);

    // Never locks: timeout and repeated HOLD.
    w0 = l0 + 7;
    expect_at(w0,      "nl_wait",        2'd1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0);
    expect_at(w0 + 31, "nl_wait_last",   2'd1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0);
    expect_at(w0 + 32, "nl_timeout",     2'd0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b1);
    expect_at(w0 + 35, "nl_hold_end",    2'd0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b1);
    expect_at(w0 + 36, "nl_wait2",       2'd1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1);
    expect_at(w0 + 68, "nl_timeout2",    2'd0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b1);
    goto(w0 + 68);

    // Lock returns; flag stays sticky into RUN.
    pll_locked = 1'b1;
    expect_at(w0 + 72, "rl_wait",   2'd1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1);
    expect_at(w0 + 73, "rl_stable", 2'd2, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1);
    expect_at(w0 + 80, "rl_pre_run",2'd2, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1);
    expect_at(w0 + 81, "rl_run",    2'd3, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1);
    goto(w0 + 81);

    // Restart in RUN, then a lock glitch during STABLE.
    r0 = cyc;
    restart = 1'b1;
    expect_at(r0 + 1,  "rs_hold",       2'd0, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0);
    expect_at(r0 + 5,  "rs_wait",       2'd1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0);
    expect_at(r0 + 6,  "rs_stable",     2'd2, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0);
    expect_at(r0 + 11, "gl_stable",     2'd2, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0);
    expect_at(r0 + 12, "gl_wait",       2'd1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0);
    expect_at(r0 + 14, "gl_wait_end",   2'd1, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0);
    expect_at(r0 + 15, "gl_stable2",    2'd2, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0);
    expect_at(r0 + 22, "gl_pre_run",    2'd2, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0);
    expect_at(r0 + 23, "gl_run",        2'd3, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0);
    goto(r0 + 1);
    restart = 1'b0;
    goto(r0 + 9);
    pll_locked = 1'b0;
    goto(r0 + 12);
    pll_locked = 1'b1;
    goto(r0 + 23);

    // 300 loss/relock cycles: relock_count saturates at 255.
    x0 = cyc;
    for (int i = 0; i < 300; i++) begin
      x = x0 + 16 * i;
      rc_exp = (2 + i > 255) ? 255 : 2 + i;
      goto(x);
      pll_locked = 1'b0;
      expect_at(x + 3,  "sat_loss",  2'd0, 1'b1, 1'b1, 1'b0, 8'(rc_exp), 1'b0);
      expect_at(x + 16, "sat_relock",2'd3, 1'b0, 1'b0, 1'b1, 8'(rc_exp), 1'b0);
      goto(x + 3);
      pll_locked = 1'b1;
    end
    x = x0 + 16 * 300;
    goto(x);

    // Asynchronous reset asserted between edges during STABLE.
    pll_locked = 1'b0;
    expect_at(x + 9,  "ar_stable", 2'd2, 1'b0, 1'b1, 1'b0, 8'd255, 1'b0);
    expect_at(x + 10, "ar_async",  2'd0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0);
    goto(x + 3);
    pll_locked = 1'b1;
    goto(x + 10);
    #1;
    rst = 1'b1;
    goto(x + 12);
    rst = 1'b0;
    c0 = cyc;
    expect_at(c0 + 3,  "ar_hold_end", 2'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    expect_at(c0 + 4,  "ar_wait",     2'd1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    expect_at(c0 + 5,  "ar_stable2",  2'd2, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    expect_at(c0 + 13, "ar_run",      2'd3, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
    goto(c0 + 15);

    if (q.size() > 0) begin
      tests += q.size();
      fails += q.size();
      $display("FAIL scoreboard_drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
